// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a scanned, active-low 7-segment bus.
// A {digit_sel, segments} pair must hold STABLE_CYCLES edges to commit.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segments_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] data_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    err
);

  localparam int PW = NUM_DIGITS + 7;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 2);

  logic [PW-1:0]           smp_q, smp_d, cur;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] data_q, data_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_q, upd_d;
  logic                    err_q, err_d;

  logic       same, commit, onehot;
  logic       is_dig, is_blank;
  logic [3:0] dig;

  assign cur    = {digit_sel, segments_in};
  assign same   = (cur == smp_q);
  // Fires once per stable period: the counter saturates past the hit value.
  assign commit = same && (cnt_q == CNT_HIT);
  assign onehot = (digit_sel != '0) &&
    ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);

  always_comb begin
    dig      = 4'hF;
    is_dig   = 1'b0;
    is_blank = 1'b0;
    case (segments_in)
      7'b1000000: begin dig = 4'd0; is_dig = 1'b1; end
      7'b1111001: begin dig = 4'd1; is_dig = 1'b1; end
      7'b0100100: begin dig = 4'd2; is_dig = 1'b1; end
      7'b0110000: begin dig = 4'd3; is_dig = 1'b1; end
      7'b0011001: begin dig = 4'd4; is_dig = 1'b1; end
      7'b0010010: begin dig = 4'd5; is_dig = 1'b1; end
      7'b0000010: begin dig = 4'd6; is_dig = 1'b1; end
      7'b1111000: begin dig = 4'd7; is_dig = 1'b1; end
      7'b0000000: begin dig = 4'd8; is_dig = 1'b1; end
      7'b0010000: begin dig = 4'd9; is_dig = 1'b1; end
      7'b1111111: is_blank = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    smp_d   = cur;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    upd_d   = 1'b0;
    err_d   = err_clr ? 1'b0 : err_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (commit && onehot) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_sel[i]) begin
          valid_d[i] = is_dig;
          if (is_dig || is_blank) begin
            data_d[4*i +: 4] = dig;
          end
        end
      end
      if (is_dig || is_blank) begin
        upd_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '1;
      valid_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign data_out    = data_q;
  assign digit_valid = valid_q;
  assign update      = upd_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed checks for seg7_scan_decoder with 4 digits, 4-edge qualify.
module tb_seg7_scan_decoder;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  segments_in = SB;
  logic [3:0]  digit_sel = 4'b0000;
  logic        err_clr = 1'b0;
  logic [15:0] data_out;
  logic [3:0]  digit_valid;
  logic        update;
  logic        err;

  int vec  = 0;
  int miss = 0;
  int upd_n;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .segments_in(segments_in),
    .digit_sel(digit_sel), .err_clr(err_clr), .data_out(data_out),
    .digit_valid(digit_valid), .update(update), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (update === 1'b1) upd_n++;
    end
  endtask

  task automatic show(input logic [3:0] s, input logic [6:0] p,
                      input int n);
    digit_sel   = s;
    segments_in = p;
    run(n);
  endtask

  initial begin
    run(2);
    chk("rst_data", data_out, 16'hFFFF);
    chk("rst_valid", digit_valid, 4'h0);
    chk("rst_update", update, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;

    upd_n = 0;
    show(4'b0001, S2, 3);
    chk("t1_early_upd", upd_n, 0);
    chk("t1_early_data", data_out, 16'hFFFF);
    run(1);
    chk("t1_data", data_out, 16'hFFF2);
    chk("t1_valid", digit_valid, 4'b0001);
    chk("t1_update", update, 1'b1);
    chk("t1_err", err, 1'b0);
    run(1);
    chk("t1_upd_drop", update, 1'b0);

    upd_n = 0;
    show(4'b0001, S7, 3);
    show(4'b0010, S9, 4);
    chk("t2_data", data_out, 16'hFF92);
    chk("t2_valid", digit_valid, 4'b0011);
    run(3);
    chk("t2_upd_cnt", upd_n, 1);

    upd_n = 0;
    show(4'b0001, S1, 6);
    show(4'b0010, S7, 6);
    show(4'b0100, S8, 6);
    show(4'b1000, S0, 6);
    chk("t3_data", data_out, 16'h0871);
    chk("t3_valid", digit_valid, 4'hF);
    chk("t3_upd_cnt", upd_n, 4);
    upd_n = 0;
    run(10);
    chk("t3_hold_upd", upd_n, 0);

    show(4'b0100, S5, 4);
    chk("t4_five", data_out, 16'h0571);
    upd_n = 0;
    show(4'b0100, SX, 4);
    chk("t4_err", err, 1'b1);
    chk("t4_valid", digit_valid, 4'b1011);
    chk("t4_data", data_out, 16'h0571);
    chk("t4_no_upd", upd_n, 0);
    show(4'b1000, SX, 3);
    err_clr = 1'b1;
    run(1);
    chk("t4_set_wins", err, 1'b1);
    chk("t4_valid3", digit_valid, 4'b0011);
    run(1);
    chk("t4_clr", err, 1'b0);
    err_clr = 1'b0;
    run(3);
    chk("t4_clr_stays", err, 1'b0);

    upd_n = 0;
    show(4'b0001, SB, 4);
    chk("blank_data", data_out, 16'h057F);
    chk("blank_valid", digit_valid, 4'b0010);
    chk("blank_upd", upd_n, 1);
    chk("blank_err", err, 1'b0);

    upd_n = 0;
    show(4'b0000, S1, 10);
    show(4'b0011, S1, 10);
    chk("t5_data", data_out, 16'h057F);
    chk("t5_valid", digit_valid, 4'b0010);
    chk("t5_upd", upd_n, 0);
    chk("t5_err", err, 1'b0);

    show(4'b0001, S4, 4);
    show(4'b0010, S3, 4);
    show(4'b0100, S2, 4);
    show(4'b1000, S1, 4);
    chk("t6_load", data_out, 16'h1234);
    chk("t6_valid", digit_valid, 4'hF);
    show(4'b0001, S2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_data", data_out, 16'hFFFF);
    chk("t6_async_valid", digit_valid, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    upd_n = 0;
    run(3);
    chk("t6_requal_data", data_out, 16'hFFFF);
    chk("t6_requal_upd", upd_n, 0);
    run(1);
    chk("t6_commit", data_out, 16'hFFF2);
    chk("t6_commit_upd", update, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
